// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one operand pair and sweeps the combinational ALU
// through all eight opcodes. Each result is captured and streamed out with its
// opcode tag. Optional self-check model: define ALU_OP_SEQUENCER_CHECK_EN.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPC   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPC-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OPC-1:0]   out_op,
  output logic             out_last,
  output logic             busy,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_d, alu_b_d, out_data_d;
  logic [OPC-1:0]   alu_ctrl_d, out_op_d;
  logic             out_valid_d, out_last_d, in_ready_d, busy_d;

  // Next-state and next-register values for the sweep sequencer
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
    alu_ctrl_d  = alu_ctrl;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_op_d    = out_op;
    out_last_d  = out_last;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          alu_a_d    = in_a;
          alu_b_d    = in_b;
          alu_ctrl_d = '0;
          state_d    = S_DRIVE;
        end
      end
      S_DRIVE: begin
        out_data_d  = alu_result;
        out_op_d    = alu_ctrl;
        out_last_d  = &alu_ctrl;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last) begin
            state_d = S_IDLE;
          end else begin
            alu_ctrl_d = alu_ctrl + OPC'(1);
            state_d    = S_DRIVE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags registered from the next state: no input-to-output path
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_ctrl  <= alu_ctrl_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_op    <= out_op_d;
      out_last  <= out_last_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
    end
  end

`ifdef ALU_OP_SEQUENCER_CHECK_EN
  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] ref_result_c;
  logic             mismatch_d;

  // Reference ALU using the team opcode encoding
  always_comb begin
    ref_result_c = '0;
    unique case (alu_ctrl)
      OPC'(0): ref_result_c = alu_a + alu_b;
      OPC'(1): ref_result_c = alu_a - alu_b;
      OPC'(2): ref_result_c = alu_a & alu_b;
      OPC'(3): ref_result_c = alu_a | alu_b;
      OPC'(4): ref_result_c = alu_a ^ alu_b;
      OPC'(5): ref_result_c = WIDTH'(alu_a < alu_b);
      OPC'(6): ref_result_c = alu_a << alu_b[SHW-1:0];
      OPC'(7): ref_result_c = alu_a >> alu_b[SHW-1:0];
      default: ref_result_c = '0;
    endcase
    mismatch_d = mismatch | ((state_q == S_DRIVE) && (ref_result_c != alu_result));
  end

  // Sticky mismatch flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch <= 1'b0;
    else        mismatch <= mismatch_d;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU in the loop.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b, alu_a, alu_b, alu_result, out_data;
  logic [2:0] alu_ctrl, out_op;
  logic       out_valid, out_ready, out_last, busy, mismatch;
  logic       fault;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_10_5  [8] = '{8'd15, 8'd5, 8'd0, 8'd15, 8'd15, 8'd0, 8'd64, 8'd0};
  logic [7:0] exp_255_1 [8] = '{8'd0, 8'd254, 8'd1, 8'd255, 8'd254, 8'd0, 8'd254, 8'd127};
  logic [7:0] exp_0_1   [8] = '{8'd1, 8'd255, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .OPC(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_op(out_op), .out_last(out_last), .busy(busy), .mismatch(mismatch)
  );

  // Combinational ALU stand-in; fault adds one to the XOR result
  always_comb begin
    case (alu_ctrl)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = (alu_a ^ alu_b) + 8'(fault);
      3'd5: alu_result = 8'(alu_a < alu_b);
      3'd6: alu_result = alu_a << alu_b[2:0];
      default: alu_result = alu_a >> alu_b[2:0];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("start_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a result, check it, optionally stall, then accept it
  task automatic take(input string tag, input logic [7:0] d, input logic [2:0] op, input int hold);
    wait_valid(tag);
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_op"}, 32'(out_op), 32'(op));
    check({tag, "_last"}, 32'(out_last), 32'(op == 3'd7));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_data"}, 32'(out_data), 32'(d));
      check({tag, "_hold_op"}, 32'(out_op), 32'(op));
      check({tag, "_hold_ctrl"}, 32'(alu_ctrl), 32'(op));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; fault = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep with out_ready held high: exact 16-cycle cadence
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd10; in_b = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    check("sw_busy", 32'(busy), 32'd1);
    check("sw_in_ready", 32'(in_ready), 32'd0);
    check("sw_alu_a", 32'(alu_a), 32'd10);
    check("sw_alu_b", 32'(alu_b), 32'd5);
    check("sw_v1", 32'(out_valid), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        check("sw_valid", 32'(out_valid), 32'd1);
        check("sw_data", 32'(out_data), 32'(exp_10_5[i/2-1]));
        check("sw_op", 32'(out_op), 32'(i/2-1));
        check("sw_last", 32'(out_last), 32'(i == 16));
        check("sw_in_ready_busy", 32'(in_ready), 32'd0);
      end else begin
        check("sw_gap", 32'(out_valid), 32'd0);
        check("sw_ctrl", 32'(alu_ctrl), 32'((i-1)/2));
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("sw_end_in_ready", 32'(in_ready), 32'd1);
    check("sw_end_busy", 32'(busy), 32'd0);
    check("sw_end_ctrl", 32'(alu_ctrl), 32'd7);
    check("sw_end_mismatch", 32'(mismatch), 32'd0);

    // Backpressure on op 2 for five cycles
    start(8'd10, 8'd5);
    for (int k = 0; k < 8; k++) take("bp", exp_10_5[k], 3'(k), (k == 2) ? 5 : 0);

    // Operands offered mid-sweep must be ignored
    start(8'd10, 8'd5);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
        @(negedge clk);
        check("ign_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
      end
      take("ign", exp_10_5[k], 3'(k), 0);
    end
    check("ign_alu_a", 32'(alu_a), 32'd10);
    check("ign_alu_b", 32'(alu_b), 32'd5);

    // Wrap and extreme operands
    start(8'd255, 8'd1);
    for (int k = 0; k < 8; k++) take("x255", exp_255_1[k], 3'(k), 0);
    start(8'd0, 8'd1);
    for (int k = 0; k < 8; k++) take("x0", exp_0_1[k], 3'(k), 0);

    // Reset mid-sweep after the third result
    start(8'd10, 8'd5);
    for (int k = 0; k < 3; k++) take("pre_rst", exp_10_5[k], 3'(k), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_data", 32'(out_data), 32'd0);
    check("mr_out_op", 32'(out_op), 32'd0);
    check("mr_out_last", 32'(out_last), 32'd0);
    check("mr_alu_a", 32'(alu_a), 32'd0);
    check("mr_alu_b", 32'(alu_b), 32'd0);
    check("mr_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    start(8'd10, 8'd5);
    for (int k = 0; k < 8; k++) take("post_rst", exp_10_5[k], 3'(k), 0);

`ifdef ALU_OP_SEQUENCER_CHECK_EN
    // Corrupt the op-4 result and watch the sticky flag
    fault = 1'b1;
    start(8'd10, 8'd5);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) check("chk_drive4", 32'(mismatch), 32'd0);
      wait_valid("chk");
      check("chk_flag", 32'(mismatch), 32'(k >= 4));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    fault = 1'b0;
    repeat (3) @(negedge clk);
    check("chk_sticky", 32'(mismatch), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("chk_cleared", 32'(mismatch), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
